// File: rtl/snake_line_prefetch.sv
// Tile-row scheduler for the snake display: prefetches the next video line into a
// ping-pong line buffer and shares the tile-map port with host writes.
module snake_line_prefetch #(
    parameter logic [10:0] H_TRIGGER = 11'd0,
    parameter logic [9:0]  V_ACTIVE  = 10'd480,
    parameter logic [9:0]  V_TOTAL   = 10'd525,
    parameter int          COLS      = 20
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [10:0] hcount,
    input  logic [9:0]  vcount,
    input  logic [15:0] bg_color,
    input  logic        host_write,
    input  logic [8:0]  host_addr,
    input  logic [3:0]  host_data,
    output logic        host_waitreq,
    output logic [8:0]  map_addr,
    output logic        map_we,
    output logic [3:0]  map_wdata,
    input  logic [3:0]  map_rdata,
    output logic [13:0] rom_addr,
    input  logic [15:0] rom_rdata,
    output logic        lb_we,
    output logic [10:0] lb_waddr,
    output logic [15:0] lb_wdata,
    output logic        disp_bank,
    output logic        busy,
    output logic        overrun,
    input  logic        clear_overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAP_REQ,
        S_MAP_WAIT,
        S_PIX,
        S_DRAIN
    } state_t;

    localparam logic [4:0] LAST_COL = 5'(COLS - 1);

    state_t      state_q;
    logic [4:0]  col_q;
    logic [4:0]  px_q;
    logic [8:0]  tgt_q;
    logic [3:0]  idx_q;
    logic        lb_we_q;
    logic [10:0] lb_waddr_q;
    logic        bg_sel_q;
    logic        overrun_q;

    logic [9:0]  tgt_d;
    logic        trigger;
    logic [8:0]  map_req_addr;

    always_comb begin
        tgt_d        = (vcount == V_TOTAL - 10'd1) ? 10'd0 : vcount + 10'd1;
        trigger      = (hcount == H_TRIGGER) && (tgt_d < V_ACTIVE);
        map_req_addr = 9'(tgt_q[8:5]) * 9'(COLS) + 9'(col_q);
    end

    // The prefetcher owns the map port only in MAP_REQ; otherwise host writes pass straight through.
    always_comb begin
        host_waitreq = 1'b0;
        map_we       = 1'b0;
        map_addr     = 9'd0;
        map_wdata    = 4'd0;
        if (state_q == S_MAP_REQ) begin
            map_addr     = map_req_addr;
            host_waitreq = host_write;
        end else if (host_write) begin
            map_we    = 1'b1;
            map_addr  = host_addr;
            map_wdata = host_data;
        end
    end

    // NOTE: reset is sampled on the clock edge, so it sits inside the clocked block, and all
    // state updates use <= so every register sees the pre-edge values of its neighbours.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q    <= S_IDLE;
            col_q      <= 5'd0;
            px_q       <= 5'd0;
            tgt_q      <= 9'd0;
            idx_q      <= 4'd0;
            lb_we_q    <= 1'b0;
            lb_waddr_q <= 11'd0;
            bg_sel_q   <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // Pixel issued in PIX lands in the line buffer one cycle later, when ROM data returns.
            lb_we_q    <= (state_q == S_PIX) && !trigger;
            lb_waddr_q <= {tgt_q[0], col_q, px_q};
            bg_sel_q   <= (idx_q == 4'd0);

            if (trigger && state_q != S_IDLE) begin
                overrun_q <= 1'b1;
            end else if (clear_overrun) begin
                overrun_q <= 1'b0;
            end

            if (trigger) begin
                state_q <= S_MAP_REQ;
                col_q   <= 5'd0;
                px_q    <= 5'd0;
                tgt_q   <= tgt_d[8:0];
            end else begin
                case (state_q)
                    S_IDLE:     state_q <= S_IDLE;
                    S_MAP_REQ:  state_q <= S_MAP_WAIT;
                    S_MAP_WAIT: begin
                        idx_q   <= map_rdata;
                        px_q    <= 5'd0;
                        state_q <= S_PIX;
                    end
                    S_PIX: begin
                        px_q <= px_q + 5'd1;
                        if (px_q == 5'd31) begin
                            if (col_q == LAST_COL) begin
                                state_q <= S_DRAIN;
                            end else begin
                                col_q   <= col_q + 5'd1;
                                state_q <= S_MAP_REQ;
                            end
                        end
                    end
                    S_DRAIN:    state_q <= S_IDLE;
                    default:    state_q <= S_IDLE;
                endcase
            end
        end
    end

    assign rom_addr  = (state_q == S_PIX) ? {idx_q - 4'd1, tgt_q[4:0], px_q} : 14'd0;
    assign lb_we     = lb_we_q;
    assign lb_waddr  = lb_waddr_q;
    assign lb_wdata  = lb_we_q ? (bg_sel_q ? bg_color : rom_rdata) : 16'd0;
    assign disp_bank = vcount[0];
    assign busy      = (state_q != S_IDLE);
    assign overrun   = overrun_q;

endmodule

// File: tb/tb_snake_line_prefetch.sv
// Self-checking bench for snake_line_prefetch: map RAM and sprite ROM models plus a
// scoreboard of expected line-buffer writes, popped as the DUT writes.
module tb_snake_line_prefetch;

    logic        clk = 1'b0;
    logic        reset;
    logic [10:0] hcount;
    logic [9:0]  vcount;
    logic [15:0] bg_color;
    logic        host_write;
    logic [8:0]  host_addr;
    logic [3:0]  host_data;
    logic        host_waitreq;
    logic [8:0]  map_addr;
    logic        map_we;
    logic [3:0]  map_wdata;
    logic [3:0]  map_rdata;
    logic [13:0] rom_addr;
    logic [15:0] rom_rdata;
    logic        lb_we;
    logic [10:0] lb_waddr;
    logic [15:0] lb_wdata;
    logic        disp_bank;
    logic        busy;
    logic        overrun;
    logic        clear_overrun;

    always #10 clk = ~clk;

    snake_line_prefetch dut (
        .clk           (clk),
        .reset         (reset),
        .hcount        (hcount),
        .vcount        (vcount),
        .bg_color      (bg_color),
        .host_write    (host_write),
        .host_addr     (host_addr),
        .host_data     (host_data),
        .host_waitreq  (host_waitreq),
        .map_addr      (map_addr),
        .map_we        (map_we),
        .map_wdata     (map_wdata),
        .map_rdata     (map_rdata),
        .rom_addr      (rom_addr),
        .rom_rdata     (rom_rdata),
        .lb_we         (lb_we),
        .lb_waddr      (lb_waddr),
        .lb_wdata      (lb_wdata),
        .disp_bank     (disp_bank),
        .busy          (busy),
        .overrun       (overrun),
        .clear_overrun (clear_overrun)
    );

    typedef struct packed {
        logic [10:0] addr;
        logic [15:0] data;
    } wr_t;

    wr_t  sb[$];
    wr_t  mon_w;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   busy_cnt = 0;
    int   wr_cnt   = 0;
    int   first_wr = -1;
    int   trig_cyc = 0;
    int   cyc      = 0;
    logic [3:0] map_mem [0:511];

    function automatic logic [15:0] rom_f(input logic [13:0] a);
        return {a, 2'b01} ^ 16'h5A3C;
    endfunction

    function automatic logic [9:0] tgt_of(input logic [9:0] v);
        return (v == 10'd524) ? 10'd0 : v + 10'd1;
    endfunction

    always @(posedge clk) begin
        if (map_we) map_mem[map_addr] <= map_wdata;
        map_rdata <= map_mem[map_addr];
        rom_rdata <= rom_f(rom_addr);
        cyc       <= cyc + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (busy === 1'b1) busy_cnt++;
        if (lb_we === 1'b1) begin
            wr_cnt++;
            if (first_wr < 0) first_wr = cyc;
            if (sb.size() == 0) begin
                check("lb_spurious", 32'(lb_we), 32'd0);
            end else begin
                mon_w = sb.pop_front();
                check("lb_waddr", 32'(lb_waddr), 32'(mon_w.addr));
                check("lb_wdata", 32'(lb_wdata), 32'(mon_w.data));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_line(input logic [9:0] v);
        logic [9:0] t;
        logic [3:0] idx;
        wr_t        w;
        t = tgt_of(v);
        for (int c = 0; c < 20; c++) begin
            idx = map_mem[int'(t[8:5]) * 20 + c];
            for (int p = 0; p < 32; p++) begin
                w.addr = {t[0], 10'(c * 32 + p)};
                w.data = (idx == 4'd0) ? bg_color : rom_f({idx - 4'd1, t[4:0], 5'(p)});
                sb.push_back(w);
            end
        end
    endtask

    task automatic start_line(input logic [9:0] v);
        vcount = v;
        push_line(v);
        busy_cnt = 0;
        wr_cnt   = 0;
        first_wr = -1;
        trig_cyc = cyc;
        hcount   = 11'd0;
        step();
        hcount   = 11'd1;
    endtask

    task automatic finish_line(input string tag);
        int i;
        i = 0;
        while (busy === 1'b1 && i < 3000) begin
            step();
            i++;
        end
        check({tag, "_timeout"}, 32'(busy), 32'd0);
        check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'd681);
        check({tag, "_writes"}, 32'(wr_cnt), 32'd640);
        check({tag, "_sb_left"}, 32'(sb.size()), 32'd0);
        check({tag, "_latency"}, 32'(first_wr - trig_cyc), 32'd4);
    endtask

    task automatic host_wr(input logic [8:0] a, input logic [3:0] d);
        int i;
        host_write = 1'b1;
        host_addr  = a;
        host_data  = d;
        #1;
        i = 0;
        while (host_waitreq && i < 10) begin
            step();
            i++;
        end
        if (i >= 10) check("host_wait_timeout", 32'(host_waitreq), 32'd0);
        step();
        host_write = 1'b0;
    endtask

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int i;
        reset         = 1'b0;
        hcount        = 11'd1;
        vcount        = 10'd1;
        bg_color      = 16'd0;
        host_write    = 1'b0;
        host_addr     = 9'd0;
        host_data     = 4'd0;
        clear_overrun = 1'b0;
        repeat (3) step();
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_lb_we", 32'(lb_we), 32'd0);
        check("rst_map_we", 32'(map_we), 32'd0);
        check("rst_overrun", 32'(overrun), 32'd0);
        check("rst_waitreq", 32'(host_waitreq), 32'd0);
        check("rst_rom_addr", 32'(rom_addr), 32'd0);
        check("rst_disp_bank", 32'(disp_bank), 32'd1);
        reset = 1'b1;
        step();

        for (int a = 0; a < 300; a++) host_wr(9'(a), 4'd0);

        // Empty map: every pixel is the background colour, bank 0.
        bg_color = 16'h07E0;
        start_line(10'd9);
        finish_line("bg_line");

        // Random tile indices on map row 6.
        for (int c = 0; c < 20; c++) host_wr(9'(120 + c), 4'($urandom_range(0, 15)));
        bg_color = 16'h001F;
        start_line(10'd200);
        finish_line("rand_line");

        // Single sprite tile at column 3 of row 0, frame-wrap target line.
        host_wr(9'd3, 4'd5);
        bg_color = 16'hF800;
        start_line(10'd524);
        finish_line("wrap_line");

        // Host write held across a MAP_REQ cycle.
        start_line(10'd100);
        host_write = 1'b1;
        host_addr  = 9'd42;
        host_data  = 4'd7;
        #1;
        check("arb_waitreq_req", 32'(host_waitreq), 32'd1);
        check("arb_map_we_req", 32'(map_we), 32'd0);
        check("arb_map_addr_req", 32'(map_addr), 32'd60);
        step();
        #1;
        check("arb_waitreq_next", 32'(host_waitreq), 32'd0);
        check("arb_map_we_next", 32'(map_we), 32'd1);
        check("arb_map_addr_next", 32'(map_addr), 32'd42);
        check("arb_map_wdata_next", 32'(map_wdata), 32'd7);
        step();
        host_write = 1'b0;
        finish_line("arb_line");
        check("arb_mem42", 32'(map_mem[42]), 32'd7);

        // Last visible line, then the blanking lines, then line 0 again.
        start_line(10'd478);
        finish_line("last_line");
        for (int v = 479; v <= 523; v++) begin
            vcount = 10'(v);
            hcount = 11'd0;
            step();
            hcount = 11'd1;
            step();
            step();
            check("blank_busy", 32'(busy), 32'd0);
        end
        start_line(10'd524);
        finish_line("line0_again");

        // Overrun: retrigger mid-line, restart for the new target line.
        start_line(10'd300);
        i = 0;
        while (busy_cnt < 300 && i < 1000) begin
            step();
            i++;
        end
        vcount = 10'd301;
        hcount = 11'd0;
        step();
        hcount = 11'd1;
        sb.delete();
        push_line(10'd301);
        busy_cnt = 0;
        wr_cnt   = 0;
        first_wr = -1;
        trig_cyc = cyc - 1;
        check("ovr_set", 32'(overrun), 32'd1);
        finish_line("ovr_line");
        check("ovr_sticky", 32'(overrun), 32'd1);
        clear_overrun = 1'b1;
        step();
        clear_overrun = 1'b0;
        check("ovr_cleared", 32'(overrun), 32'd0);

        // Set and clear together (set wins), then reset in the middle of PIX.
        start_line(10'd50);
        repeat (40) step();
        vcount        = 10'd51;
        hcount        = 11'd0;
        clear_overrun = 1'b1;
        step();
        hcount        = 11'd1;
        clear_overrun = 1'b0;
        sb.delete();
        push_line(10'd51);
        check("ovr_set_wins", 32'(overrun), 32'd1);
        repeat (30) step();
        reset = 1'b0;
        step();
        sb.delete();
        step();
        step();
        reset = 1'b1;
        check("midrst_busy", 32'(busy), 32'd0);
        check("midrst_lb_we", 32'(lb_we), 32'd0);
        check("midrst_map_we", 32'(map_we), 32'd0);
        check("midrst_overrun", 32'(overrun), 32'd0);
        repeat (20) step();
        check("midrst_idle", 32'(busy), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
